qpoint_accum_sequencer: RTL and testbench
=========================================

// Module: qpoint_accum_sequencer
// PURPOSE
//  Sequences the Q-point adder to integrate one neuron's synaptic input in a spiking layer.
//  - On start, walks the weight memory over NUM_W entries (weights are signed Q1.7, INP_WIDTH bits).
//  - Feeds weight k through the external Qpoint_Adder whenever the spike bit for entry k is set.
//  - Accumulates into a saturating ACC_WIDTH membrane-potential register.
//  - Reports the result with a done pulse.
//  - Sits between the weight/spike memories and the neuron threshold logic.
// PARAMETERS
//  INP_WIDTH   8    weight width, signed, 7 fractional bits
//  ACC_WIDTH   12   accumulator width, signed, 7 fractional bits
//  NUM_W       125  weights per integration pass (>=1)
//  ADDR_WIDTH  7    memory address width; must satisfy 2**ADDR_WIDTH >= NUM_W
// PORTS
//  clk          in   1              single clock, rising edge
//  rst_n        in   1              asynchronous, active-low reset
//  start        in   1              begin a pass; sampled only in IDLE
//  abort        in   1              synchronous cancel of a running pass
//  w_rd_en      out  1              weight/spike memory read strobe
//  w_addr       out  ADDR_WIDTH     read address
//  w_data       in   INP_WIDTH      weight; valid 1 cycle after w_rd_en
//  spk_in       in   1              spike bit for the same address; same latency as w_data
//  add_a        out  ACC_WIDTH      adder operand A = current accumulator
//  add_b        out  ACC_WIDTH      adder operand B = sign-extended weight (or 0 when no spike)
//  add_c        in   ACC_WIDTH+1    combinational adder sum
//  busy         out  1              high outside IDLE
//  done         out  1              1-cycle pulse; acc_out valid
//  acc_out      out  ACC_WIDTH      final potential; held until the next done
//  sat_flag     out  1              saturation occurred during the last pass; held with acc_out
//  spike_count  out  ADDR_WIDTH+1   number of spikes counted in the last pass
// BEHAVIOUR
//  Reset
//  - All outputs 0. Accumulator 0. State IDLE. Asserting rst_n low mid-pass discards the pass.
//  FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE
//  - IDLE: start=1 at an edge clears acc, sat and count, sets addr=0 and enters RUN.
//  - RUN: w_rd_en=1 and w_addr increments each cycle from 0 to NUM_W-1.
//    - After issuing NUM_W-1, the FSM moves to DRAIN.
//  - DRAIN: w_rd_en=0. The last returned word is accumulated.
//  - DONE: done=1 for one cycle. acc_out, sat_flag and spike_count are registered here. Then IDLE.
//  Datapath pipeline
//  - A valid bit, delayed 1 cycle from w_rd_en, qualifies w_data/spk_in.
//  - When valid && spk_in:
//    - acc <= sat(add_c)
//    - spike_count++
//  - When valid && !spk_in: acc is held and add_b=0.
//  - add_a/add_b are combinational from acc and w_data.
//  Latency
//  - With start sampled at edge T, done is high during the cycle after edge T+NUM_W+2.
//  - Total = NUM_W+3 cycles including IDLE->DONE->IDLE.
//  Saturation
//  - If add_c > 2**(ACC_WIDTH-1)-1, clamp to max. If add_c < -2**(ACC_WIDTH-1), clamp to min.
//  - sat_flag is sticky for the pass.
//  Control rules
//  - start while busy is ignored (no restart, no queueing).
//  - abort while busy returns to IDLE next edge: w_rd_en=0, no done.
//    acc_out, sat_flag and spike_count keep the previous pass's values.
//  - abort and start in the same IDLE cycle: abort wins, stay IDLE.
//  - abort in the DONE cycle has no effect; done still pulses.
// TESTING
//  - All spk=1, all w=8'h01, NUM_W=125:
//    acc_out=12'd125 (0.9765625), spike_count=125, sat_flag=0, done NUM_W+2 edges after start.
//  - All spk=1, w=8'h7F:
//    clamp on the 17th add (2032+127>2047), acc_out=12'h7FF, sat_flag=1.
//  - All spk=1, w=8'h80:
//    acc clamps to 12'h800 (-2048) on the 17th add, sat_flag=1.
//  - spk=1 only at even addresses, w[k]=+1 even / -5 odd:
//    acc_out=63, spike_count=63. All spk=0 -> acc_out=0, spike_count=0.
//  - start pulsed again at RUN cycle 10: ignored, a single done.
//    abort at cycle 40: no done, prior acc_out retained.
//  - rst_n low mid-RUN: all outputs 0 asynchronously.
//    After release, a fresh start completes normally.

Source files
------------

// File: rtl/qpoint_accum_sequencer_if.sv
// Bundles the weight/spike memory port, the external Q-point adder port and the
// pass control/result signals of the accumulation sequencer.
interface qpoint_accum_if #(
  parameter int INP_WIDTH  = 8,
  parameter int ACC_WIDTH  = 12,
  parameter int ADDR_WIDTH = 7
);
  logic                         start;
  logic                         abort;
  logic                         w_rd_en;
  logic        [ADDR_WIDTH-1:0] w_addr;
  logic signed [INP_WIDTH-1:0]  w_data;
  logic                         spk_in;
  logic signed [ACC_WIDTH-1:0]  add_a;
  logic signed [ACC_WIDTH-1:0]  add_b;
  logic signed [ACC_WIDTH:0]    add_c;
  logic                         busy;
  logic                         done;
  logic signed [ACC_WIDTH-1:0]  acc_out;
  logic                         sat_flag;
  logic        [ADDR_WIDTH:0]   spike_count;

  modport slave (
    input  start, abort, w_data, spk_in, add_c,
    output w_rd_en, w_addr, add_a, add_b, busy, done, acc_out, sat_flag, spike_count
  );

  modport master (
    output start, abort, w_data, spk_in, add_c,
    input  w_rd_en, w_addr, add_a, add_b, busy, done, acc_out, sat_flag, spike_count
  );
endinterface

// File: rtl/qpoint_accum_sequencer.sv
// Walks the weight/spike memory once per start, feeding spiking weights through the
// external Q-point adder into a saturating membrane-potential accumulator.
module qpoint_accum_sequencer #(
  parameter int INP_WIDTH  = 8,
  parameter int ACC_WIDTH  = 12,
  parameter int NUM_W      = 125,
  parameter int ADDR_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  qpoint_accum_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0]       LAST_ADDR = ADDR_WIDTH'(NUM_W - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                       r_state;
  logic                         r_rd_en;
  logic        [ADDR_WIDTH-1:0] r_addr;
  logic                         r_vld_p1;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_sat;
  logic        [ADDR_WIDTH:0]   r_cnt;
  logic                         r_done;
  logic signed [ACC_WIDTH-1:0]  r_acc_out;
  logic                         r_sat_out;
  logic        [ADDR_WIDTH:0]   r_cnt_out;

  logic                         w_hit;
  logic                         w_ovf;

  // A sum whose two top bits disagree has left the ACC_WIDTH range.
  function automatic logic signed [ACC_WIDTH-1:0] sat_sum(input logic signed [ACC_WIDTH:0] s);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[ACC_WIDTH-1:0];
  endfunction

  assign w_hit = r_vld_p1 & bus.spk_in;
  assign w_ovf = bus.add_c[ACC_WIDTH] ^ bus.add_c[ACC_WIDTH-1];

  assign bus.add_a       = r_acc;
  assign bus.add_b       = w_hit ? {{(ACC_WIDTH-INP_WIDTH){bus.w_data[INP_WIDTH-1]}}, bus.w_data}
                                 : '0;
  assign bus.w_rd_en     = r_rd_en;
  assign bus.w_addr      = r_addr;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.acc_out     = r_acc_out;
  assign bus.sat_flag    = r_sat_out;
  assign bus.spike_count = r_cnt_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_vld_p1  <= 1'b0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_acc_out <= '0;
      r_sat_out <= 1'b0;
      r_cnt_out <= '0;
    end else begin
      r_done   <= 1'b0;
      r_vld_p1 <= r_rd_en;

      // p1: returned word is valid; integrate it when its spike bit is set
      if (w_hit) begin
        r_acc <= sat_sum(bus.add_c);
        r_sat <= r_sat | w_ovf;
        r_cnt <= r_cnt + (ADDR_WIDTH+1)'(1);
      end

      unique case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rd_en <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_rd_en  <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_addr == LAST_ADDR) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (bus.abort) begin
            r_vld_p1 <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_acc_out <= r_acc;
          r_sat_out <= r_sat;
          r_cnt_out <= r_cnt;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpoint_accum_sequencer.sv
// Bench for qpoint_accum_sequencer: memory and adder models, table-driven passes
// with a result scoreboard, plus restart, abort and reset sequences.
module tb_qpoint_accum_sequencer;
  localparam int INP_W = 8;
  localparam int ACC_W = 12;
  localparam int NW    = 125;
  localparam int AW    = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpoint_accum_if #(.INP_WIDTH(INP_W), .ACC_WIDTH(ACC_W), .ADDR_WIDTH(AW)) bus ();

  qpoint_accum_sequencer #(.INP_WIDTH(INP_W), .ACC_WIDTH(ACC_W), .NUM_W(NW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic signed [ACC_W-1:0] acc;
    logic [AW:0]             cnt;
    logic                    sat;
  } res_t;

  typedef struct {
    int         spk_mode;   // 0 all spikes, 1 even addresses only, 2 none
    logic [7:0] w_even;
    logic [7:0] w_odd;
    res_t       exp;
  } vec_t;

  res_t        sb_q[$];
  vec_t        vecs[5];
  logic [7:0]  mem_w[0:(1<<AW)-1];
  logic        mem_s[0:(1<<AW)-1];
  int          errs = 0;
  int          checks = 0;

  // External combinational adder and 1-cycle-latency weight/spike memory
  assign bus.add_c = {bus.add_a[ACC_W-1], bus.add_a} + {bus.add_b[ACC_W-1], bus.add_b};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.w_data <= '0;
      bus.spk_in <= 1'b0;
    end else if (bus.w_rd_en) begin
      bus.w_data <= mem_w[bus.w_addr];
      bus.spk_in <= mem_s[bus.w_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input vec_t v);
    for (int k = 0; k < (1<<AW); k++) begin
      mem_w[k] = (k % 2 == 0) ? v.w_even : v.w_odd;
      mem_s[k] = (v.spk_mode == 0) ? 1'b1 : (v.spk_mode == 1) ? (k % 2 == 0) : 1'b0;
    end
  endtask

  function automatic res_t model_pass();
    res_t r;
    int acc = 0;
    r.cnt = '0;
    r.sat = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (mem_s[k]) begin
        acc = acc + int'($signed(mem_w[k]));
        if (acc > 2047) begin acc = 2047; r.sat = 1'b1; end
        if (acc < -2048) begin acc = -2048; r.sat = 1'b1; end
        r.cnt = r.cnt + 1'b1;
      end
    end
    r.acc = ACC_W'(acc);
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic compare_result(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_acc"}, 32'(bus.acc_out), 32'(e.acc));
    chk({tag, "_cnt"}, 32'(bus.spike_count), 32'(e.cnt));
    chk({tag, "_sat"}, 32'(bus.sat_flag), 32'(e.sat));
  endtask

  // Waits for done; 'elapsed' is the number of edges since the start edge already consumed
  task automatic wait_done(input string tag, input int elapsed);
    int lat = -1;
    for (int i = elapsed + 1; i <= NW + 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NW + 2));
    if (lat > 0) begin
      compare_result(tag);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse_1cyc"}, 32'(bus.done), 32'd0);
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
    chk({tag, "_no_done"}, 32'(n), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;

    vecs[0] = '{0, 8'h01, 8'h01, '{12'sd125, 8'd125, 1'b0}};
    vecs[1] = '{0, 8'h7F, 8'h7F, '{12'sh7FF, 8'd125, 1'b1}};
    vecs[2] = '{0, 8'h80, 8'h80, '{12'sh800, 8'd125, 1'b1}};
    vecs[3] = '{1, 8'h01, 8'hFB, '{12'sd63,  8'd63,  1'b0}};
    vecs[4] = '{2, 8'h7F, 8'h7F, '{12'sd0,   8'd0,   1'b0}};

    #1;
    chk("rst_acc_out", 32'(bus.acc_out), 32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_rd_en",   32'(bus.w_rd_en), 32'd0);
    chk("rst_add_a",   32'(bus.add_a),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v]);
      sb_q.push_back(vecs[v].exp);
      pulse_start();
      chk($sformatf("vec%0d_busy", v),  32'(bus.busy),    32'd1);
      chk($sformatf("vec%0d_rd_en", v), 32'(bus.w_rd_en), 32'd1);
      wait_done($sformatf("vec%0d", v), 0);
    end

    for (int k = 0; k < (1<<AW); k++) begin
      mem_w[k] = 8'($urandom_range(0, 255));
      mem_s[k] = 1'($urandom_range(0, 1));
    end
    sb_q.push_back(model_pass());
    pulse_start();
    wait_done("random", 0);

    // Second start during RUN is ignored
    fill(vecs[1]);
    sb_q.push_back(vecs[1].exp);
    pulse_start();
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("restart", 10);
    expect_no_done("restart", NW + 10);

    // Abort mid-RUN keeps the previous result
    fill(vecs[0]);
    pulse_start();
    repeat (39) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy",  32'(bus.busy),    32'd0);
    chk("abort_rd_en", 32'(bus.w_rd_en), 32'd0);
    expect_no_done("abort", NW + 10);
    chk("abort_acc_kept", 32'(bus.acc_out),     32'h7FF);
    chk("abort_sat_kept", 32'(bus.sat_flag),    32'd1);
    chk("abort_cnt_kept", 32'(bus.spike_count), 32'd125);

    // Abort together with start in IDLE wins
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_idle", 32'(bus.busy), 32'd0);

    // Abort during DONE does not suppress the pulse
    fill(vecs[3]);
    sb_q.push_back(vecs[3].exp);
    pulse_start();
    repeat (NW + 1) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_in_done_pulse", 32'(bus.done), 32'd1);
    compare_result("abort_in_done");

    // Asynchronous reset mid-RUN, then a fresh pass
    fill(vecs[2]);
    pulse_start();
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_acc_out", 32'(bus.acc_out),     32'd0);
    chk("midrst_cnt",     32'(bus.spike_count), 32'd0);
    chk("midrst_busy",    32'(bus.busy),        32'd0);
    chk("midrst_rd_en",   32'(bus.w_rd_en),     32'd0);
    chk("midrst_addr",    32'(bus.w_addr),      32'd0);
    chk("midrst_add_a",   32'(bus.add_a),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill(vecs[0]);
    sb_q.push_back(vecs[0].exp);
    pulse_start();
    wait_done("post_reset", 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
